// File: rtl/instr_encoder_loader.sv
// ============================================================================
// instr_encoder_loader
//
// Purpose:
//   Encodes instruction fields (mnemonic, rs, rt, rd, imm, target) into the
//   32-bit words consumed by the control decoder and streams them into
//   instruction memory at consecutive word addresses starting at BASE_ADDR.
//   Internally: a small encoded-word FIFO, a byte-address counter and a
//   three-state load FSM (IDLE -> LOAD -> DRAIN_DONE -> IDLE).
//
// Parameters:
//   FIFO_DEPTH  encoded-word buffer entries (power of 2, >= 2)
//   ADDR_W      imem byte-address width
//   BASE_ADDR   first byte address written after start
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 pulse: begin a load (ignored while busy)
//   in_valid / in_ready   instruction-field handshake
//   in_op                 mnemonic 0..10 (11..15 illegal)
//   in_rs/in_rt/in_rd     register fields
//   in_imm, in_target     immediate / jump target
//   in_last               final instruction of this load
//   imem_we/addr/wdata    imem write port, held stable while imem_ready=0
//   imem_ready            memory accepts the write this cycle
//   busy                  FSM not IDLE
//   done                  one-cycle pulse after the last word is written
//   err_illegal           sticky since start: an illegal op was offered
//   checksum              XOR of written words (ENC_CHECKSUM_EN), else 0
//
// Build option:
//   ENC_CHECKSUM_EN  when defined, checksum accumulates the XOR of every
//                    imem_wdata written since start; otherwise tied to 0.
// ============================================================================
module instr_encoder_loader #(
    parameter int                FIFO_DEPTH = 4,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic [31:0]       checksum
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // FIFO entry: {last tag, real word (write it), encoded word}
    logic [33:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_err;
    logic               r_last_taken;

    logic [33:0]        w_head;
    logic               w_head_last;
    logic               w_head_real;
    logic               w_empty;
    logic               w_full;
    logic               w_active;
    logic               w_pop;
    logic               w_xfer;
    logic               w_legal;
    logic               w_push;
    logic [31:0]        w_word;

    function automatic logic [31:0] f_encode(
        input logic [3:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm,
        input logic [25:0] tgt
    );
        logic [31:0] w;
        w = '0;
        case (op)
            4'd0:    w = {6'b100000, rs, rt, rd, 11'd0};   // and
            4'd1:    w = {6'b100011, rs, rt, imm};         // lw
            4'd2:    w = {6'b101011, rs, rt, imm};         // sw
            4'd3:    w = {6'b001000, rs, 21'd0};           // jr
            4'd4:    w = {6'b000011, tgt};                 // jal
            4'd5:    w = {6'b100110, rs, rt, rd, 11'd0};   // nor
            4'd6:    w = {6'b001110, rs, rt, imm};         // nori
            4'd7:    w = {6'b000100, rs, rt, rd, 11'd0};   // not
            4'd8:    w = {6'b010000, rs, rt, imm};         // bleu
            4'd9:    w = {6'b000000, rs, rt, rd, 11'd0};   // rolv
            4'd10:   w = {6'b000010, rs, rt, rd, 11'd0};   // rorv
            default: w = '0;
        endcase
        return w;
    endfunction

    assign w_word  = f_encode(in_op, in_rs, in_rt, in_rd, in_imm, in_target);
    assign w_legal = (in_op <= 4'd10);

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[IDX_W] != r_rptr[IDX_W]) &&
                     (r_wptr[IDX_W-1:0] == r_rptr[IDX_W-1:0]);

    assign w_head      = r_mem[r_rptr[IDX_W-1:0]];
    assign w_head_last = w_head[33];
    assign w_head_real = w_head[32];

    // A done-marker (illegal last op) carries no word: it retires without
    // waiting for imem_ready and without advancing the address.
    assign w_active = (r_state == S_LOAD) && !w_empty;
    assign w_pop    = w_active && (!w_head_real || imem_ready);

    // A full FIFO still accepts when its head retires this cycle.
    assign in_ready = (r_state == S_LOAD) && !r_last_taken && (!w_full || w_pop);
    assign w_xfer   = in_valid && in_ready;
    // Illegal non-last ops are consumed but dropped.
    assign w_push   = w_xfer && (w_legal || in_last);

    assign imem_we     = w_active && w_head_real;
    assign imem_addr   = r_addr;
    assign imem_wdata  = imem_we ? w_head[31:0] : '0;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DRAIN_DONE);
    assign err_illegal = r_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:       if (start) w_state_nxt = S_LOAD;
            S_LOAD:       if (w_pop && w_head_last) w_state_nxt = S_DRAIN_DONE;
            S_DRAIN_DONE: w_state_nxt = S_IDLE;
            default:      w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_addr       <= BASE_ADDR;
            r_err        <= 1'b0;
            r_last_taken <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE) begin
                if (start) begin
                    r_wptr       <= '0;
                    r_rptr       <= '0;
                    r_addr       <= BASE_ADDR;
                    r_err        <= 1'b0;
                    r_last_taken <= 1'b0;
                end
            end else begin
                if (w_push) r_wptr <= r_wptr + PTR_W'(1);
                if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
                if (w_pop && w_head_real) r_addr <= r_addr + ADDR_W'(4);
                if (w_xfer && !w_legal)   r_err <= 1'b1;
                if (w_xfer && in_last)    r_last_taken <= 1'b1;
            end
        end
    end

    // Storage needs no reset: occupancy is defined solely by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[IDX_W-1:0]] <= {in_last, w_legal, w_word};
    end

`ifdef ENC_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) r_checksum <= '0;
        end else if (imem_we && imem_ready) begin
            r_checksum <= r_checksum ^ w_head[31:0];
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// ============================================================================
// tb_instr_encoder_loader
//
// Directed bench for instr_encoder_loader (FIFO_DEPTH=4, ADDR_W=32,
// BASE_ADDR=0). Expected imem writes are queued when fields are accepted and
// compared as the DUT presents each write; a monitor also checks that a
// stalled write holds its address and data.
// ============================================================================
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ready;
    logic        busy;
    logic        done;
    logic        err_illegal;
    logic [31:0] checksum;

    always #5 clk = ~clk;

    instr_encoder_loader #(
        .FIFO_DEPTH (4),
        .ADDR_W     (32),
        .BASE_ADDR  (32'h0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .in_imm      (in_imm),
        .in_target   (in_target),
        .in_last     (in_last),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .imem_ready  (imem_ready),
        .busy        (busy),
        .done        (done),
        .err_illegal (err_illegal),
        .checksum    (checksum)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_addr = 32'h0;
    int          errors   = 0;
    int          checks   = 0;
    int          cyc      = 0;
    int          wr_cyc   = -10;
    int          n_writes = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference encoding from the opcode table.
    function automatic logic [31:0] tb_encode(
        input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt
    );
        case (op)
            4'd0:    return {6'h20, rs, rt, rd, 11'd0};
            4'd1:    return {6'h23, rs, rt, imm};
            4'd2:    return {6'h2B, rs, rt, imm};
            4'd3:    return {6'h08, rs, 21'd0};
            4'd4:    return {6'h03, tgt};
            4'd5:    return {6'h26, rs, rt, rd, 11'd0};
            4'd6:    return {6'h0E, rs, rt, imm};
            4'd7:    return {6'h04, rs, rt, rd, 11'd0};
            4'd8:    return {6'h10, rs, rt, imm};
            4'd9:    return {6'h00, rs, rt, rd, 11'd0};
            4'd10:   return {6'h02, rs, rt, rd, 11'd0};
            default: return 32'h0;
        endcase
    endfunction

    // Write monitor: compares each accepted write with the scoreboard head.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr  = 32'h0;
    logic [31:0] prev_data  = 32'h0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_we",   32'(imem_we), 32'h1);
                chk("stall_addr", imem_addr, prev_addr);
                chk("stall_data", imem_wdata, prev_data);
            end
            if (imem_we && imem_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", 32'(imem_we), 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wr_addr", imem_addr, e.addr);
                    chk("wr_data", imem_wdata, e.data);
                end
                n_writes++;
                wr_cyc = cyc;
            end
            prev_stall = imem_we && !imem_ready;
            prev_addr  = imem_addr;
            prev_data  = imem_wdata;
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        exp_addr = 32'h0;
        chk("start_busy",     32'(busy), 32'h1);
        chk("start_err_clr",  32'(err_illegal), 32'h0);
        chk("start_csum_clr", checksum, 32'h0);
    endtask

    task automatic send(
        input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
        input logic last, input logic [31:0] exp_word
    );
        logic got;
        got       = 1'b0;
        in_op     = op;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_imm    = imm;
        in_target = tgt;
        in_last   = last;
        in_valid  = 1'b1;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        chk("in_ready_wait", 32'(got), 32'h1);
        if (got && op <= 4'd10) begin
            exp_t e;
            e.addr = exp_addr;
            e.data = exp_word;
            sb.push_back(e);
            exp_addr = exp_addr + 32'd4;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Random-field send: fields not used by op are randomised too, so any
    // leak into the word shows up as a data mismatch.
    task automatic send_rnd(input logic [3:0] op, input logic last);
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        rs  = 5'($urandom);
        rt  = 5'($urandom);
        rd  = 5'($urandom);
        imm = 16'($urandom);
        tgt = 26'($urandom);
        send(op, rs, rt, rd, imm, tgt, last, tb_encode(op, rs, rt, rd, imm, tgt));
    endtask

    task automatic wait_done(input logic had_write);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'h1);
        if (seen) begin
            chk("sb_drained", 32'(sb.size()), 32'h0);
            if (had_write) chk("done_latency", 32'(cyc), 32'(wr_cyc + 1));
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 32'h0);
            chk("idle_not_busy",  32'(busy), 32'h0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_before;

        rst_n      = 1'b0;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_op      = 4'd0;
        in_rs      = '0;
        in_rt      = '0;
        in_rd      = '0;
        in_imm     = '0;
        in_target  = '0;
        in_last    = 1'b0;
        imem_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_imem_we",  32'(imem_we), 32'h0);
        chk("rst_busy",     32'(busy), 32'h0);
        chk("rst_done",     32'(done), 32'h0);
        chk("rst_err",      32'(err_illegal), 32'h0);
        chk("rst_checksum", checksum, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", 32'(in_ready), 32'h0);

        // Single 'and' word
        do_start();
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h80221800);
        wait_done(1'b1);

        // and + lw: checksum of the two words
        do_start();
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 32'h80221800);
        send(4'd1, 5'd4, 5'd5, 5'd0, 16'hFFFC, 26'h0, 1'b1, 32'h8C85FFFC);
        wait_done(1'b1);
`ifdef ENC_CHECKSUM_EN
        chk("checksum_two_words", checksum, 32'h0CA7E7FC);
`else
        chk("checksum_disabled", checksum, 32'h0);
`endif

        // lw then jal (last)
        do_start();
        send(4'd1, 5'd4, 5'd5, 5'd0, 16'hFFFC, 26'h0, 1'b0, 32'h8C85FFFC);
        send(4'd4, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010, 1'b1, 32'h0C000010);
        wait_done(1'b1);

        // Backpressure: 4 words fill the FIFO while imem stalls; a start
        // pulse mid-load must not restart the address.
        wr_before = n_writes;
        do_start();
        imem_ready = 1'b0;
        send_rnd(4'd5, 1'b0);
        start = 1'b1;
        send_rnd(4'd6, 1'b0);
        start = 1'b0;
        send_rnd(4'd7, 1'b0);
        send_rnd(4'd8, 1'b0);
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'h0);
        chk("full_we",       32'(imem_we), 32'h1);
        chk("full_addr",     imem_addr, 32'h0);
        in_op    = 4'd9;
        in_valid = 1'b1;
        @(negedge clk);
        chk("full_hold_in_ready", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        in_valid   = 1'b0;
        imem_ready = 1'b1;
        send_rnd(4'd9, 1'b0);
        send_rnd(4'd10, 1'b1);
        wait_done(1'b1);
        chk("bp_write_count", 32'(n_writes - wr_before), 32'd6);

        // Mixed remaining ops, random imem_ready
        do_start();
        for (int k = 0; k < 4; k++) begin
            imem_ready = 1'($urandom);
            send_rnd(4'(k % 4 == 0 ? 2 : (k % 4 == 1 ? 3 : (k % 4 == 2 ? 0 : 4))), 1'(k == 3));
        end
        imem_ready = 1'b1;
        wait_done(1'b1);

        // Illegal op as last: no write, sticky error, done still pulses
        wr_before = n_writes;
        do_start();
        send(4'd12, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h0, 1'b1, 32'h0);
        wait_done(1'b0);
        chk("illegal_no_write", 32'(n_writes - wr_before), 32'h0);
        chk("illegal_err_set",  32'(err_illegal), 32'h1);

        // Next start clears it; illegal non-last is dropped, address unaffected
        wr_before = n_writes;
        do_start();
        send(4'd15, 5'd7, 5'd7, 5'd7, 16'hFFFF, 26'h3FFFFFF, 1'b0, 32'h0);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h80221800);
        wait_done(1'b1);
        chk("illegal_mid_one_write", 32'(n_writes - wr_before), 32'h1);
        chk("illegal_mid_err",       32'(err_illegal), 32'h1);

        // Reset mid-load with 3 words queued
        do_start();
        imem_ready = 1'b0;
        send_rnd(4'd1, 1'b0);
        send_rnd(4'd2, 1'b0);
        send_rnd(4'd5, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_we",       32'(imem_we), 32'h0);
        chk("midrst_busy",     32'(busy), 32'h0);
        chk("midrst_in_ready", 32'(in_ready), 32'h0);
        chk("midrst_done",     32'(done), 32'h0);
        sb.delete();
        @(posedge clk); #1;
        rst_n      = 1'b1;
        imem_ready = 1'b1;
        @(posedge clk); #1;
        do_start();
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h80221800);
        wait_done(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
